encoder_4x2_request_serializer: RTL

Registered 4-to-2 request encoder: the inverse of the 2x4 one-hot decoder. It captures single-cycle or level requests on four one-hot request lines into a pending register. It emits them one at a time as 2-bit binary codes over a valid/ready handshake, clearing each bit once it is presented. It sits between the event sources and the decoder/dispatch path, so several simultaneous requests are serialized rather than lost.

---
 rtl/encoder_4x2_request_serializer_if.sv | 46 ++++
 rtl/encoder_4x2_request_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/encoder_4x2_request_serializer_if.sv
// ----------------------------------------------------------------------------
// encoder_4x2_request_serializer_if
//
// Bundles the request inputs, the valid/ready code handshake and the status
// outputs of the 4-to-2 request serializer.
//
//   en    : request capture enable (into serializer)
//   a[3:0]: one-hot request lines, bit i requests code i (into serializer)
//   rdy   : downstream ready (into serializer)
//   y[1:0]: presented binary code (out of serializer)
//   vld   : y holds a valid code (out of serializer)
//   pend  : requests captured but not yet presented (out of serializer)
//   ovf   : sticky merge flag (out of serializer)
//
// Modports: master = the serializer itself, slave = request sources plus the
// downstream consumer.
// ----------------------------------------------------------------------------
interface encoder_4x2_request_serializer_if;
    logic       en;
    logic [3:0] a;
    logic       rdy;
    logic [1:0] y;
    logic       vld;
    logic [3:0] pend;
    logic       ovf;

    modport master (
        input  en,
        input  a,
        input  rdy,
        output y,
        output vld,
        output pend,
        output ovf
    );

    modport slave (
        output en,
        output a,
        output rdy,
        input  y,
        input  vld,
        input  pend,
        input  ovf
    );
endinterface

// File: rtl/encoder_4x2_request_serializer.sv
// ----------------------------------------------------------------------------
// encoder_4x2_request_serializer
//
// Captures requests on four one-hot lines into a pending register and emits
// them one at a time as 2-bit codes over a valid/ready handshake, so that
// simultaneous requests are serialized instead of lost.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : encoder_4x2_request_serializer_if.master
//           (en, a, rdy in; y, vld, pend, ovf out)
//
// Build option:
//   ENC_ROUND_ROBIN_EN - when defined, selection is round-robin starting after
//   the last loaded code; otherwise the lowest set index wins.
// ----------------------------------------------------------------------------
module encoder_4x2_request_serializer (
    input  logic                                  clk,
    input  logic                                  rst_n,
    encoder_4x2_request_serializer_if.master      bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] y_q, y_d;
    logic [3:0] pend_q, pend_d;
    logic       ovf_q, ovf_d;

    logic [3:0] req_in;
    logic [3:0] cand;
    logic       take;
    logic       load;
    logic [1:0] sel_idx;

`ifdef ENC_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Search starts one past the last loaded index and wraps; walking the
    // offsets from farthest to nearest lets the nearest set bit win.
    function automatic logic [1:0] select_rr(input logic [3:0] v, input logic [1:0] last);
        logic [1:0] idx;
        select_rr = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (v[idx]) begin
                select_rr = idx;
            end
        end
    endfunction
`else
    function automatic logic [1:0] select_fixed(input logic [3:0] v);
        if (v[0]) begin
            select_fixed = 2'd0;
        end else if (v[1]) begin
            select_fixed = 2'd1;
        end else if (v[2]) begin
            select_fixed = 2'd2;
        end else begin
            select_fixed = 2'd3;
        end
    endfunction
`endif

    always_comb begin
        req_in = bus.en ? bus.a : 4'b0000;
        cand   = pend_q | req_in;
        // Slot is free, or the presented code leaves on this edge.
        take   = (state_q == ST_EMPTY) || bus.rdy;
        load   = take && (cand != 4'b0000);
`ifdef ENC_ROUND_ROBIN_EN
        sel_idx = select_rr(cand, ptr_q);
        ptr_d   = load ? sel_idx : ptr_q;
`else
        sel_idx = select_fixed(cand);
`endif

        state_d = state_q;
        y_d     = y_q;
        pend_d  = cand;
        // Only bits already pending count as merged; the presented code is
        // not in pend, so re-requesting it simply queues it again.
        ovf_d   = ovf_q | (|(pend_q & req_in));

        if (take) begin
            if (cand != 4'b0000) begin
                state_d = ST_FULL;
                y_d     = sel_idx;
                pend_d  = cand & ~(4'b0001 << sel_idx);
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            y_q     <= 2'b00;
            pend_q  <= 4'b0000;
            ovf_q   <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q   <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.y    = y_q;
    assign bus.vld  = (state_q == ST_FULL);
    assign bus.pend = pend_q;
    assign bus.ovf  = ovf_q;

endmodule
